// File: rtl/audio_pkg.sv
// Shared widths and fetch-state encoding for the sample playback path.
package audio_pkg;
  localparam int ADDR_W   = 20;
  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    WAIT,
    CAPTURE
  } fetch_state_e;
endpackage

// File: rtl/sample_fifo.sv
// Small synchronous FIFO buffering SRAM samples ahead of the codec.
// Head word is visible combinationally on dout; flush empties it in one edge.
module sample_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 16,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy tracking; flush behaves like reset.
  always_ff @(posedge Clk) begin
    if (Reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/sram_sample_reader.sv
// Streams 16-bit samples from an async SRAM into a small FIFO and hands
// them to the codec one per sample_req, with optional looping playback.
module sram_sample_reader
  import audio_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   length,
  input  logic                loop_en,
  input  logic                stop,
  input  logic                sample_req,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                underflow,
  output logic [ADDR_W-1:0]   SRAM_ADDR,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                tristate_write_enable,
  input  logic [SAMPLE_W-1:0] Data_read
);
  localparam int FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0]  WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [FAW:0]   FIFO_CAP  = (FAW+1)'(FIFO_DEPTH);

  fetch_state_e state, state_nx;

  logic [ADDR_W-1:0]   rd_addr, remaining, base_q, len_q;
  logic                loop_q, stop_pend, strobe_n;
  logic [CW-1:0]       wait_cnt;
  logic                fifo_full, fifo_empty;
  logic [FAW:0]        fifo_count;
  logic [SAMPLE_W-1:0] fifo_dout;
  logic                start_ok, stop_act, capture, push, pop, flush;

  // stop beats a same-cycle start; a stop seen mid-read is parked in stop_pend
  // until the read reaches CAPTURE so the SRAM cycle is never cut short.
  assign start_ok = start && !stop && !busy && (length != '0);
  assign stop_act = busy && (stop || stop_pend) && (state == IDLE || state == CAPTURE);
  assign pop      = sample_req && !fifo_empty;
  assign push     = capture && !stop_act && (!fifo_full || pop);
  assign flush    = start_ok || stop_act;

  assign SRAM_CE_N             = strobe_n;
  assign SRAM_OE_N             = strobe_n;
  assign SRAM_UB_N             = strobe_n;
  assign SRAM_LB_N             = strobe_n;
  assign SRAM_WE_N             = 1'b1;
  assign tristate_write_enable = 1'b0;

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .Clk   (Clk),
    .Reset (Reset),
    .flush (flush),
    .push  (push),
    .din   (Data_read),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Fetch state register.
  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Fetch next-state: launch only while room remains; nothing is in flight
  // while IDLE, so occupancy alone bounds buffered plus outstanding reads.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    unique case (state)
      IDLE:    if (busy && !stop_act && remaining != '0 && fifo_count < FIFO_CAP)
                 state_nx = ADDR;
      ADDR:    state_nx = (WAIT_CYCLES == 0) ? CAPTURE : WAIT;
      WAIT:    if (wait_cnt == '0) state_nx = CAPTURE;
      CAPTURE: begin
        state_nx = IDLE;
        capture  = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // SRAM strobes/address, playback bookkeeping and codec-side output register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      strobe_n     <= 1'b1;
      SRAM_ADDR    <= '0;
      wait_cnt     <= '0;
      rd_addr      <= '0;
      remaining    <= '0;
      base_q       <= '0;
      len_q        <= '0;
      loop_q       <= 1'b0;
      stop_pend    <= 1'b0;
      busy         <= 1'b0;
      underflow    <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= sample_req;
      if (sample_req) sample_out <= pop ? fifo_dout : '0;

      if (start_ok)                            underflow <= 1'b0;
      else if (sample_req && busy && fifo_empty) underflow <= 1'b1;

      stop_pend <= busy && !stop_act && (stop || stop_pend);

      if (start_ok)
        busy <= 1'b1;
      else if (stop_act)
        busy <= 1'b0;
      else if (busy && state == IDLE && !loop_q && remaining == '0 && fifo_empty)
        busy <= 1'b0;

      if (state == ADDR) begin
        SRAM_ADDR <= rd_addr;
        strobe_n  <= 1'b0;
        wait_cnt  <= WAIT_LOAD;
      end
      if (state == WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
      if (capture) strobe_n <= 1'b1;

      if (start_ok) begin
        base_q    <= base_addr;
        len_q     <= length;
        loop_q    <= loop_en;
        rd_addr   <= base_addr;
        remaining <= length;
      end else if (capture && !stop_act) begin
        // Looping reloads on the last word so the next fetch follows immediately.
        if (loop_q && remaining == ADDR_W'(1)) begin
          rd_addr   <= base_q;
          remaining <= len_q;
        end else begin
          rd_addr   <= rd_addr + 1'b1;
          remaining <= remaining - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sram_sample_reader.sv
// Bench for sram_sample_reader: table-driven playback jobs, directed corner
// sequences and randomized codec traffic against an address/data stream model.
module tb_sram_sample_reader;
  localparam int WAIT_CYCLES = 2;
  localparam int FIFO_DEPTH  = 4;

  logic        Clk = 1'b0, Reset = 1'b1, start = 1'b0, loop_en = 1'b0;
  logic        stop = 1'b0, sample_req = 1'b0;
  logic [19:0] base_addr = '0, length = '0;
  logic [15:0] sample_out, Data_read = '0;
  logic        sample_valid, busy, underflow;
  logic [19:0] SRAM_ADDR;
  logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N, tristate_write_enable;

  int checks = 0, failures = 0;

  sram_sample_reader #(.WAIT_CYCLES(WAIT_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr), .length(length),
    .loop_en(loop_en), .stop(stop), .sample_req(sample_req), .sample_out(sample_out),
    .sample_valid(sample_valid), .busy(busy), .underflow(underflow), .SRAM_ADDR(SRAM_ADDR),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .tristate_write_enable(tristate_write_enable), .Data_read(Data_read)
  );

  always #5 Clk = ~Clk;

  // ---------------- memory model: non-zero contents everywhere ----------------
  logic [15:0] mem_ovr [int];
  function automatic logic [15:0] memv(input logic [19:0] a);
    logic [31:0] h;
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    h = {12'h0, a} * 32'd2654435761;
    return h[31:16] | 16'h0001;
  endfunction

  always @(posedge Clk) Data_read <= memv(SRAM_ADDR);

  // ---------------- playback stream model ----------------
  logic [19:0] m_base = '0;
  int          m_len = 1;
  logic        m_loop = 1'b0;
  int          rd_k = 0, smp_k = 0, reads = 0;

  function automatic logic [19:0] model_addr(input int k);
    int off;
    off = m_loop ? (k % m_len) : k;
    return m_base + off[19:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- cycle monitor ----------------
  logic ce_prev = 1'b1, req_prev = 1'b0, rst_prev = 1'b1;
  int   low_cnt = 0;
  always @(negedge Clk) begin
    if (!Reset) begin
      chk("we_n_high", SRAM_WE_N, 1);
      chk("tristate_off", tristate_write_enable, 0);
      chk("strobes_agree", {SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, {3{SRAM_CE_N}});
      if (!rst_prev) chk("valid_follows_req", sample_valid, req_prev);
      if (ce_prev && !SRAM_CE_N) begin
        chk("read_addr", SRAM_ADDR, model_addr(rd_k));
        rd_k++;
        reads++;
        low_cnt = 0;
      end
      if (!SRAM_CE_N) low_cnt++;
      else if (!ce_prev && !rst_prev) chk("strobe_width", low_cnt, WAIT_CYCLES + 1);
      if (sample_valid && sample_out != 16'h0) begin
        chk("sample_data", sample_out, memv(model_addr(smp_k)));
        smp_k++;
      end
    end
    ce_prev  = SRAM_CE_N;
    req_prev = sample_req;
    rst_prev = Reset;
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1; start = 1'b0; stop = 1'b0; sample_req = 1'b0;
    tick(1);
    Reset = 1'b0;
    rd_k = 0; smp_k = 0; reads = 0;
  endtask

  task automatic do_start(input logic [19:0] b, input logic [19:0] l, input logic lp);
    base_addr = b; length = l; loop_en = lp; start = 1'b1;
    if (l != 20'h0) begin
      m_base = b; m_len = int'(l); m_loop = lp;
      rd_k = 0; smp_k = 0; reads = 0;
    end
    tick(1);
    start = 1'b0;
  endtask

  task automatic pop_one();
    sample_req = 1'b1;
    tick(1);
    sample_req = 1'b0;
  endtask

  task automatic wait_ce_low(input int bound);
    for (int i = 0; i < bound && SRAM_CE_N; i++) tick(1);
    chk("read_launch_timeout", SRAM_CE_N, 0);
  endtask

  task automatic wait_busy_low(input int bound);
    for (int i = 0; i < bound && busy; i++) tick(1);
  endtask

  typedef struct {
    logic [19:0] base;
    logic [19:0] len;
    logic        lp;
    int          exp_reads;      // reads after filling with no requests
    logic [19:0] exp_last;       // SRAM_ADDR of the last fill read
    logic        exp_busy;       // busy after fill
    int          exp_reads_end;  // reads after draining exp_reads samples
    logic        exp_busy_end;   // busy after the drain settles
  } vec_t;

  vec_t vecs[7];

  initial begin
    mem_ovr[32'h00100] = 16'hAAAA;
    mem_ovr[32'h00101] = 16'hBBBB;
    mem_ovr[32'h00102] = 16'hCCCC;

    vecs[0] = '{20'h00100, 20'd3,  1'b0, 3, 20'h00102, 1'b1, 3, 1'b0};
    vecs[1] = '{20'hFFFFF, 20'd2,  1'b1, 4, 20'h00000, 1'b1, 8, 1'b1};
    vecs[2] = '{20'h12345, 20'd10, 1'b0, 4, 20'h12348, 1'b1, 8, 1'b1};
    vecs[3] = '{20'h00050, 20'd0,  1'b0, 0, 20'h00000, 1'b0, 0, 1'b0};
    vecs[4] = '{20'hFFFFE, 20'd1,  1'b0, 1, 20'hFFFFE, 1'b1, 1, 1'b0};
    vecs[5] = '{20'h00200, 20'd3,  1'b1, 4, 20'h00200, 1'b1, 8, 1'b1};
    vecs[6] = '{20'hFFFFE, 20'd4,  1'b0, 4, 20'h00001, 1'b1, 4, 1'b0};

    // ---- reset state ----
    tick(2);
    Reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_sample_out", sample_out, 0);
    chk("rst_sample_valid", sample_valid, 0);
    chk("rst_sram_addr", SRAM_ADDR, 0);
    chk("rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 4'hF);
    chk("rst_fifo_count", dut.u_fifo.count, 0);

    // ---- table-driven playback jobs ----
    for (int v = 0; v < 7; v++) begin
      do_reset();
      do_start(vecs[v].base, vecs[v].len, vecs[v].lp);
      chk("busy_after_start", busy, vecs[v].len != 20'h0);
      tick(40);
      chk("fill_reads", reads, vecs[v].exp_reads);
      chk("fill_last_addr", SRAM_ADDR, vecs[v].exp_last);
      chk("fill_idle_ce", SRAM_CE_N, 1);
      chk("fill_busy", busy, vecs[v].exp_busy);
      for (int p = 0; p < vecs[v].exp_reads; p++) begin
        pop_one();
        tick(8);
      end
      tick(30);
      chk("drain_samples", smp_k, vecs[v].exp_reads);
      chk("drain_reads", reads, vecs[v].exp_reads_end);
      chk("drain_busy", busy, vecs[v].exp_busy_end);
    end

    // ---- reset in the middle of a read ----
    do_reset();
    do_start(20'h00300, 20'd5, 1'b0);
    tick(25);
    pop_one();
    tick(1);
    chk("pre_reset_sample", sample_out, memv(20'h00300));
    wait_ce_low(12);
    tick(1);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("midread_rst_strobes", {SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}, 4'hF);
    chk("midread_rst_busy", busy, 0);
    chk("midread_rst_sample_out", sample_out, 0);
    chk("midread_rst_addr", SRAM_ADDR, 0);
    chk("midread_rst_fifo", dut.u_fifo.count, 0);

    // ---- underflow with requests every cycle ----
    do_reset();
    do_start(20'h00400, 20'd6, 1'b0);
    chk("uf_busy", busy, 1);
    sample_req = 1'b1;
    tick(1);
    chk("uf_first_valid", sample_valid, 1);
    chk("uf_first_silence", sample_out, 0);
    chk("uf_first_flag", underflow, 1);
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("uf_sticky", underflow, 1);
    end
    sample_req = 1'b0;
    tick(2);
    chk("uf_all_samples", smp_k, 6);
    chk("uf_busy_done", busy, 0);
    chk("uf_held_idle", underflow, 1);
    pop_one();
    chk("idle_req_silence", sample_out, 0);
    chk("idle_req_no_new_uf", sample_valid, 1);
    do_start(20'h00400, 20'd1, 1'b0);
    chk("uf_cleared_by_start", underflow, 0);
    tick(20);

    // ---- stop during WAIT, with a colliding start ----
    do_reset();
    do_start(20'h00500, 20'd10, 1'b0);
    wait_ce_low(10);
    stop = 1'b1; start = 1'b1; base_addr = 20'h00777; length = 20'd5;
    tick(1);
    stop = 1'b0; start = 1'b0;
    wait_busy_low(WAIT_CYCLES + 3);
    chk("stop_busy_low", busy, 0);
    tick(20);
    chk("stop_one_read", reads, 1);
    chk("stop_fifo_empty", dut.u_fifo.count, 0);
    chk("stop_start_ignored", SRAM_ADDR, 20'h00500);
    pop_one();
    chk("stop_pop_silence", sample_out, 0);
    chk("stop_no_underflow", underflow, 0);
    chk("stop_data_dropped", smp_k, 0);

    // ---- full FIFO, then pop coinciding with a CAPTURE push ----
    do_reset();
    do_start(20'h00600, 20'd10, 1'b0);
    tick(30);
    chk("full_reads", reads, FIFO_DEPTH);
    chk("full_idle_ce", SRAM_CE_N, 1);
    chk("full_count", dut.u_fifo.count, FIFO_DEPTH);
    pop_one();
    wait_ce_low(10);
    tick(WAIT_CYCLES);
    chk("capture_strobes_on", SRAM_CE_N, 0);
    chk("capture_count_before", dut.u_fifo.count, FIFO_DEPTH - 1);
    pop_one();
    chk("pushpop_count", dut.u_fifo.count, FIFO_DEPTH - 1);
    chk("pushpop_strobes_off", SRAM_CE_N, 1);
    tick(15);
    chk("refill_count", dut.u_fifo.count, FIFO_DEPTH);
    chk("refill_reads", reads, FIFO_DEPTH + 2);

    // ---- randomized codec traffic ----
    for (int it = 0; it < 8; it++) begin
      logic [19:0] b, l;
      logic        lp;
      b  = (it % 3 == 0) ? 20'hFFFFF - 20'($urandom_range(0, 4)) : 20'($urandom);
      l  = 20'($urandom_range(1, 12));
      lp = (it % 2 == 1);
      do_reset();
      do_start(b, l, lp);
      for (int c = 0; c < 200; c++) begin
        sample_req = ($urandom_range(0, 3) == 0);
        tick(1);
      end
      sample_req = 1'b0;
      if (!lp) begin
        for (int i = 0; i < 300 && busy; i++) begin
          sample_req = (i % 2 == 0);
          tick(1);
        end
        sample_req = 1'b0;
        tick(2);
        chk("rnd_done", busy, 0);
        chk("rnd_samples", smp_k, int'(l));
        chk("rnd_reads", reads, int'(l));
      end else begin
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        wait_busy_low(WAIT_CYCLES + 6);
        chk("rnd_stop_busy", busy, 0);
        chk("rnd_stop_fifo", dut.u_fifo.count, 0);
      end
    end

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
